// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - shared opcodes, state encoding and IR field positions for the control sequencer

package control_pkg;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

    localparam logic [OPC_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OPC_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPC_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OPC_W-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        ST_RESET,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_T7,
        ST_HALTED
    } state_e;

    typedef struct packed {
        logic ld;
        logic ldi;
        logic st;
        logic addi;
        logic nop;
        logic halt;
        logic bad;
    } op_class_t;

    typedef struct packed {
        logic pc_out;
        logic pc_in;
        logic inc_pc;
        logic mar_in;
        logic mdr_in;
        logic mdr_out;
        logic mdmux_read;
        logic ir_in;
        logic y_in;
        logic zlow_in;
        logic zlow_out;
        logic cse_out;
        logic add;
        logic gra;
        logic grb;
        logic r_in;
        logic r_out;
        logic ba_out;
        logic ram_read;
        logic ram_write;
    } strobes_t;

endpackage

// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - sequencer to datapath control bundle

interface control_sequencer_if #(
    parameter int IR_W = 32
);
    logic [IR_W-1:0] ir;
    logic            stop;
    logic            run;
    logic            illegal;
    logic            dp_clear;
    logic            PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread, IRin;
    logic            Yin, Zlowin, Zlowout, CSEout, ADD;
    logic            Gra, Grb, Rin, Rout, BAout, RAMread, RAMwrite;

    modport master (
        input  ir, stop,
        output run, illegal, dp_clear,
        output PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread, IRin,
        output Yin, Zlowin, Zlowout, CSEout, ADD,
        output Gra, Grb, Rin, Rout, BAout, RAMread, RAMwrite
    );

    modport slave (
        output ir, stop,
        input  run, illegal, dp_clear,
        input  PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread, IRin,
        input  Yin, Zlowin, Zlowout, CSEout, ADD,
        input  Gra, Grb, Rin, Rout, BAout, RAMread, RAMwrite
    );
endinterface

// File: rtl/control_sequencer_op_decode.sv
// rtl/control_sequencer_op_decode.sv - opcode to one-hot instruction class

module op_decode
    import control_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output op_class_t        cls
);

    always_comb begin
        cls = '0;
        case (opcode)
            OP_LD:   cls.ld   = 1'b1;
            OP_LDI:  cls.ldi  = 1'b1;
            OP_ST:   cls.st   = 1'b1;
            OP_ADDI: cls.addi = 1'b1;
            OP_NOP:  cls.nop  = 1'b1;
            OP_HALT: cls.halt = 1'b1;
            default: cls.bad  = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired fetch/execute control unit driving the datapath strobes

module control_sequencer
    import control_pkg::*;
#(
    parameter int IR_W         = 32,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic               clock,
    input  logic               clear,
    control_sequencer_if.master bus
);

    localparam logic [3:0] CNT_LAST = 4'(CLEAR_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] clr_cnt_q, clr_cnt_d;
    op_class_t  cls_q, cls_d;
    op_class_t  dec;
    strobes_t   stb;
    logic       run_o, illegal_o, dp_clear_o;
    logic [IR_W-1:0] ir_w;

    assign ir_w = bus.ir;

    op_decode u_op_decode (
        .opcode (ir_w[OPC_MSB:OPC_LSB]),
        .cls    (dec)
    );

    // Only the opcode field steers sequencing; operand fields go straight to the datapath.
    wire unused_bits = &{1'b0, ir_w, dec.nop, cls_q.ldi, cls_q.addi,
                         cls_q.nop, cls_q.halt, cls_q.bad};

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q   <= ST_RESET;
            clr_cnt_q <= '0;
            cls_q     <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            cls_q     <= cls_d;
        end
    end

    always_comb begin
        state_e end_step;
        end_step  = bus.stop ? ST_HALTED : ST_T0;
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        cls_d     = cls_q;
        case (state_q)
            ST_RESET: begin
                if (clr_cnt_q == CNT_LAST) state_d = ST_T0;
                else                       clr_cnt_d = clr_cnt_q + 4'd1;
            end
            ST_T0: state_d = ST_T1;
            ST_T1: state_d = ST_T2;
            ST_T2: state_d = ST_T3;
            ST_T3: begin
                cls_d = dec;
                if (dec.halt)                                 state_d = ST_HALTED;
                else if (dec.ld | dec.ldi | dec.st | dec.addi) state_d = ST_T4;
                else                                          state_d = end_step;
            end
            ST_T4: state_d = ST_T5;
            ST_T5: state_d = (cls_q.ld | cls_q.st) ? ST_T6 : end_step;
            ST_T6: state_d = cls_q.ld ? ST_T7 : end_step;
            ST_T7: state_d = end_step;
            ST_HALTED: state_d = ST_HALTED;
            default: state_d = ST_RESET;
        endcase
    end

    // T3 reads the live IR; later execute steps use the class captured at the end of T3.
    always_comb begin
        stb        = '0;
        run_o      = 1'b0;
        illegal_o  = 1'b0;
        dp_clear_o = 1'b0;
        case (state_q)
            ST_RESET: dp_clear_o = 1'b1;
            ST_T0: begin
                run_o = 1'b1;
                stb.pc_out = 1'b1; stb.mar_in = 1'b1; stb.inc_pc = 1'b1; stb.zlow_in = 1'b1;
            end
            ST_T1: begin
                run_o = 1'b1;
                stb.zlow_out = 1'b1; stb.pc_in = 1'b1; stb.mdmux_read = 1'b1;
                stb.ram_read = 1'b1; stb.mdr_in = 1'b1;
            end
            ST_T2: begin
                run_o = 1'b1;
                stb.mdr_out = 1'b1; stb.ir_in = 1'b1;
            end
            ST_T3: begin
                run_o = 1'b1;
                if (dec.ld | dec.ldi | dec.st) begin
                    stb.grb = 1'b1; stb.ba_out = 1'b1; stb.y_in = 1'b1;
                end else if (dec.addi) begin
                    stb.grb = 1'b1; stb.r_out = 1'b1; stb.y_in = 1'b1;
                end else if (dec.bad) begin
                    illegal_o = 1'b1;
                end
            end
            ST_T4: begin
                run_o = 1'b1;
                stb.cse_out = 1'b1; stb.add = 1'b1; stb.zlow_in = 1'b1;
            end
            ST_T5: begin
                run_o = 1'b1;
                stb.zlow_out = 1'b1;
                if (cls_q.ld | cls_q.st) stb.mar_in = 1'b1;
                else begin
                    stb.gra = 1'b1; stb.r_in = 1'b1;
                end
            end
            ST_T6: begin
                run_o = 1'b1;
                if (cls_q.ld) begin
                    stb.mdmux_read = 1'b1; stb.ram_read = 1'b1; stb.mdr_in = 1'b1;
                end else begin
                    stb.gra = 1'b1; stb.r_out = 1'b1; stb.ram_write = 1'b1;
                end
            end
            ST_T7: begin
                run_o = 1'b1;
                stb.mdr_out = 1'b1; stb.gra = 1'b1; stb.r_in = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.run       = run_o;
    assign bus.illegal   = illegal_o;
    assign bus.dp_clear  = dp_clear_o;
    assign bus.PCout     = stb.pc_out;
    assign bus.PCin      = stb.pc_in;
    assign bus.IncPC     = stb.inc_pc;
    assign bus.MARin     = stb.mar_in;
    assign bus.MDRin     = stb.mdr_in;
    assign bus.MDRout    = stb.mdr_out;
    assign bus.MDMuxread = stb.mdmux_read;
    assign bus.IRin      = stb.ir_in;
    assign bus.Yin       = stb.y_in;
    assign bus.Zlowin    = stb.zlow_in;
    assign bus.Zlowout   = stb.zlow_out;
    assign bus.CSEout    = stb.cse_out;
    assign bus.ADD       = stb.add;
    assign bus.Gra       = stb.gra;
    assign bus.Grb       = stb.grb;
    assign bus.Rin       = stb.r_in;
    assign bus.Rout      = stb.r_out;
    assign bus.BAout     = stb.ba_out;
    assign bus.RAMread   = stb.ram_read;
    assign bus.RAMwrite  = stb.ram_write;

endmodule
